// File: rtl/pipeacc16_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and the registered
// read-owner tag that routes mem_rdata back to whoever issued the read.
package pipeacc16_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_HOST = 2'd2
    } owner_tag_t;

    // Counter width able to hold 0..max_v (at least one bit).
    function automatic int starve_cw(input int max_v);
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/starve_ctr.sv
// Saturating up-counter with synchronous clear; o_sat flags that the host has
// waited long enough to be forced through.
module starve_ctr
    import pipeacc16_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int            CW    = starve_cw(MAX);
    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments and an async reset
    // branch first, so every register settles to a known value without a clock.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_sat = (r_count == MAX_V);

endmodule

// File: rtl/dmem_arb.sv
// Two-requester arbiter (pipeline MEM stage and debug host) in front of a
// single-port synchronous data RAM, with a host-owned freeze mode.
module dmem_arb
    import pipeacc16_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          host_halt_req,
    output logic          cpu_frozen,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t r_state, w_state_next;
    owner_tag_t r_tag, w_tag_next;
    logic       w_cpu_gnt, w_host_gnt;
    logic       w_starve_sat, w_starve_inc, w_starve_clr;

    starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk1  (clk1),
        .rst_n (rst_n),
        .i_inc (w_starve_inc),
        .i_clr (w_starve_clr),
        .o_sat (w_starve_sat)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_tag   <= TAG_NONE;
        end else begin
            r_state <= w_state_next;
            r_tag   <= w_tag_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_host_gnt   = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                w_host_gnt = host_req & (~cpu_req | w_starve_sat);
                w_cpu_gnt  = cpu_req & ~w_host_gnt;
                if (host_halt_req) w_state_next = ST_DRAIN;
            end
            // No grants here, so any read launched in RUN completes this cycle.
            ST_DRAIN: begin
                w_state_next = host_halt_req ? ST_FROZEN : ST_RUN;
            end
            ST_FROZEN: begin
                w_host_gnt = host_req;
                if (!host_halt_req && (r_tag != TAG_HOST)) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Request-driven outputs are masked while reset is held.
    assign cpu_gnt   = w_cpu_gnt & rst_n;
    assign host_gnt  = w_host_gnt & rst_n;
    assign cpu_stall = cpu_req & ~cpu_gnt & rst_n;
    assign cpu_frozen = (r_state == ST_FROZEN);

    assign w_starve_clr = host_gnt | ~host_req;
    assign w_starve_inc = (r_state == ST_RUN) & host_req & ~host_gnt;

    always_comb begin
        w_tag_next = TAG_NONE;
        if (cpu_gnt && !cpu_we)        w_tag_next = TAG_CPU;
        else if (host_gnt && !host_we) w_tag_next = TAG_HOST;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign mem_en = cpu_gnt | host_gnt;

    assign cpu_rvalid  = (r_tag == TAG_CPU);
    assign host_rvalid = (r_tag == TAG_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_dmem_arb;

    localparam int AW         = 8;
    localparam int DW         = 16;
    localparam int STARVE_MAX = 4;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, host_req, host_we, host_halt_req;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid, cpu_frozen;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_halt_req(host_halt_req), .cpu_frozen(cpu_frozen),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 16'h1234 : DW'(16'hA000 + a);
    endfunction

    // Environment RAM: single-port, read data registered one cycle after the read.
    logic [DW-1:0] ram [256];
    bit            ram_init;
    always @(posedge clk1) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=normal, 1=draining, 2=host-owned.
    int            m_mode, m_starve, m_pend;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] m_ram [256];
    bit            m_cg, m_hg;

    initial for (int i = 0; i < 256; i++) m_ram[i] = init_val(i);

    task automatic model_cycle();
        bit            cg, hg;
        int            nmode;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (!rst_n) begin
            check("rst_cpu_gnt", cpu_gnt, 0);      check("rst_host_gnt", host_gnt, 0);
            check("rst_cpu_rvalid", cpu_rvalid, 0); check("rst_host_rvalid", host_rvalid, 0);
            check("rst_cpu_rdata", cpu_rdata, 0);   check("rst_host_rdata", host_rdata, 0);
            check("rst_cpu_stall", cpu_stall, 0);   check("rst_cpu_frozen", cpu_frozen, 0);
            check("rst_mem_en", mem_en, 0);         check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);     check("rst_mem_wdata", mem_wdata, 0);
            m_mode = 0; m_starve = 0; m_pend = 0; m_cg = 0; m_hg = 0;
            return;
        end
        case (m_mode)
            0: begin
                hg = host_req && (!cpu_req || m_starve == STARVE_MAX);
                cg = cpu_req && !hg;
            end
            1: begin hg = 0; cg = 0; end
            default: begin hg = host_req; cg = 0; end
        endcase
        ea = cg ? cpu_addr  : (hg ? host_addr  : '0);
        ed = cg ? cpu_wdata : (hg ? host_wdata : '0);
        check("cmp_cpu_gnt", cpu_gnt, cg);
        check("cmp_host_gnt", host_gnt, hg);
        check("cmp_cpu_stall", cpu_stall, cpu_req && !cg);
        check("cmp_cpu_frozen", cpu_frozen, m_mode == 2);
        check("cmp_cpu_rvalid", cpu_rvalid, m_pend == 1);
        check("cmp_host_rvalid", host_rvalid, m_pend == 2);
        check("cmp_cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pdata : '0);
        check("cmp_host_rdata", host_rdata, (m_pend == 2) ? m_pdata : '0);
        check("cmp_mem_en", mem_en, cg || hg);
        check("cmp_mem_we", mem_we, cg ? cpu_we : (hg ? host_we : 1'b0));
        check("cmp_mem_addr", mem_addr, ea);
        check("cmp_mem_wdata", mem_wdata, ed);
        // Advance the model by one clock.
        case (m_mode)
            0:       nmode = host_halt_req ? 1 : 0;
            1:       nmode = host_halt_req ? 2 : 0;
            default: nmode = (!host_halt_req && m_pend != 2) ? 0 : 2;
        endcase
        if (!host_req || hg)                          m_starve = 0;
        else if (m_mode == 0 && m_starve < STARVE_MAX) m_starve++;
        m_pend = 0;
        if (cg || hg) begin
            if ((cg && cpu_we) || (hg && host_we)) m_ram[ea] = ed;
            else begin
                m_pend  = cg ? 1 : 2;
                m_pdata = m_ram[ea];
            end
        end
        m_mode = nmode; m_cg = cg; m_hg = hg;
    endtask

    always @(negedge clk1) model_cycle();

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        host_halt_req = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle();
        cpu_req = 1; host_req = 1;
        @(negedge clk1);
        check("reset_cpu_gnt", cpu_gnt, 0);
        check("reset_host_gnt", host_gnt, 0);
        check("reset_cpu_stall", cpu_stall, 0);
        check("reset_mem_en", mem_en, 0);
        step(); rst_n = 1; idle();
        @(negedge clk1);
        check("reset_cpu_frozen", cpu_frozen, 0);

        // CPU read of preloaded word, host idle.
        step(); cpu_req = 1; cpu_addr = 8'h05;
        @(negedge clk1);
        check("t1_cpu_gnt", cpu_gnt, 1);
        check("t1_mem_addr", mem_addr, 8'h05);
        step(); cpu_req = 0;
        @(negedge clk1);
        check("t1_cpu_rvalid", cpu_rvalid, 1);
        check("t1_cpu_rdata", cpu_rdata, 16'h1234);

        // Both requesting continuously: host forced through on the 5th cycle.
        step(); cpu_req = 1; cpu_addr = 8'h20; host_req = 1; host_addr = 8'h30;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step();
            @(negedge clk1);
            check($sformatf("t2_host_gnt_c%0d", c), host_gnt, c == 5);
            check($sformatf("t2_cpu_stall_c%0d", c), cpu_stall, c == 5);
        end
        step(); host_req = 0;
        @(negedge clk1);
        check("t2_host_rvalid", host_rvalid, 1);
        check("t2_host_rdata", host_rdata, 16'hA030);

        // Simultaneous request with empty starve count: CPU first, host next.
        step(); cpu_addr = 8'h21; host_req = 1; host_addr = 8'h31;
        @(negedge clk1);
        check("t3_cpu_gnt", cpu_gnt, 1);
        check("t3_host_gnt", host_gnt, 0);
        step(); cpu_req = 0;
        @(negedge clk1);
        check("t3_host_gnt_next", host_gnt, 1);
        check("t3_cpu_rdata", cpu_rdata, 16'hA021);
        step(); host_req = 0;
        @(negedge clk1);
        check("t3_host_rdata", host_rdata, 16'hA031);

        // Halt during a CPU read: one drain cycle delivers the read, then frozen.
        step(); cpu_req = 1; cpu_addr = 8'h05; host_halt_req = 1;
        @(negedge clk1);
        check("t4_cpu_gnt", cpu_gnt, 1);
        step(); cpu_req = 0;
        @(negedge clk1);
        check("t4_cpu_rvalid", cpu_rvalid, 1);
        check("t4_cpu_rdata", cpu_rdata, 16'h1234);
        check("t4_not_frozen_yet", cpu_frozen, 0);
        step(); cpu_req = 1;
        @(negedge clk1);
        check("t4_cpu_frozen", cpu_frozen, 1);
        check("t4_cpu_stall", cpu_stall, 1);

        // Frozen: back-to-back host writes then readback.
        for (int i = 0; i < 4; i++) begin
            step(); cpu_req = 0;
            host_req = 1; host_we = 1; host_addr = AW'(8'h10 + i); host_wdata = 16'hBEEF;
            @(negedge clk1);
            check($sformatf("t5_wr_gnt_%0d", i), host_gnt, 1);
        end
        for (int i = 0; i < 4; i++) begin
            step(); host_we = 0; host_addr = AW'(8'h10 + i);
            @(negedge clk1);
            check($sformatf("t5_rd_gnt_%0d", i), host_gnt, 1);
            if (i > 0) check($sformatf("t5_rd_data_%0d", i - 1), host_rdata, 16'hBEEF);
        end
        step(); host_req = 0; host_halt_req = 0;
        @(negedge clk1);
        check("t5_rd_data_3", host_rdata, 16'hBEEF);
        check("t5_still_frozen", cpu_frozen, 1);
        repeat (3) step();

        // Reset the cycle after a host read grant: the read is discarded.
        step(); host_req = 1; host_addr = 8'h12;
        @(negedge clk1);
        check("t6_host_gnt", host_gnt, 1);
        step(); rst_n = 0; cpu_req = 1;
        @(negedge clk1);
        check("t6_rst_host_rvalid", host_rvalid, 0);
        check("t6_rst_host_rdata", host_rdata, 0);
        check("t6_rst_mem_en", mem_en, 0);
        step(); rst_n = 1; idle();
        @(negedge clk1);
        check("t6_post_host_rvalid", host_rvalid, 0);
        check("t6_post_frozen", cpu_frozen, 0);
        step(); cpu_req = 1; cpu_addr = 8'h05;
        @(negedge clk1);
        check("t6_run_cpu_gnt", cpu_gnt, 1);
        step(); idle();

        // Randomized traffic; a pending request stays stable until granted.
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!cpu_req || m_cg) begin
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = AW'($urandom_range(0, 15));
                cpu_wdata = DW'($urandom);
            end
            if (!host_req || m_hg) begin
                host_req   = ($urandom_range(0, 99) < 40);
                host_we    = $urandom_range(0, 1) == 1;
                host_addr  = AW'($urandom_range(0, 15));
                host_wdata = DW'($urandom);
            end
            if ($urandom_range(0, 99) < 4) host_halt_req = ~host_halt_req;
            rst_n = ($urandom_range(0, 999) >= 3);
        end
        step(); rst_n = 1; idle();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
